// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory line port between the icache (I) and dcache (D).
// Latency: a request seen at edge N drives pmem strobes during cycle N+1; the resp is combinational off pmem_resp.
// Backpressure: requesters hold their request until x_resp; the losing side waits in place, with round-robin on ties.
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;

    localparam logic G_I = 1'b0;
    localparam logic G_D = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] cmd_addr_q,   cmd_addr_d;
    logic [LINE_W-1:0] cmd_wdata_q,  cmd_wdata_d;
    logic              cmd_rd_q,     cmd_rd_d;
    logic              cmd_wr_q,     cmd_wr_d;

    logic i_req;
    logic d_req;
    logic serving;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign serving = (state_q == S_SERVE_I) || (state_q == S_SERVE_D);

    // Next-state: arbitrate only in IDLE; a write beats a read on the D side.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_rd_d     = cmd_rd_q;
        cmd_wr_d     = cmd_wr_q;
        case (state_q)
            S_IDLE: begin
                if (i_req && (!d_req || last_grant_q == G_D)) begin
                    state_d      = S_SERVE_I;
                    last_grant_d = G_I;
                    cmd_addr_d   = i_addr;
                    cmd_rd_d     = 1'b1;
                    cmd_wr_d     = 1'b0;
                end else if (d_req) begin
                    state_d      = S_SERVE_D;
                    last_grant_d = G_D;
                    cmd_addr_d   = d_addr;
                    cmd_wdata_d  = d_wdata;
                    cmd_rd_d     = d_read & ~d_write;
                    cmd_wr_d     = d_write;
                end
            end
            S_SERVE_I, S_SERVE_D: begin
                if (pmem_resp) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and command registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_D;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_rd_q     <= 1'b0;
            cmd_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_rd_q     <= cmd_rd_d;
            cmd_wr_q     <= cmd_wr_d;
        end
    end

    // Outputs: memory is driven from the latched command only while serving,
    // and the response is steered to the owner of the transaction.
    always_comb begin
        pmem_read  = serving & cmd_rd_q;
        pmem_write = serving & cmd_wr_q;
        pmem_addr  = serving ? cmd_addr_q  : '0;
        pmem_wdata = serving ? cmd_wdata_q : '0;
        i_resp     = (state_q == S_SERVE_I) & pmem_resp;
        d_resp     = (state_q == S_SERVE_D) & pmem_resp;
        i_rdata    = i_resp ? pmem_rdata : '0;
        d_rdata    = d_resp ? pmem_rdata : '0;
        arb_busy   = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter: a transaction-level model predicts grant order and memory commands.
// Latency: memory model answers 0..3 cycles after the strobe appears.
// Backpressure: requesters hold requests until their resp, as the real caches do.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_read, d_read, d_write;
    logic [15:0]  i_addr, d_addr;
    logic [127:0] d_wdata;
    logic [127:0] i_rdata, d_rdata;
    logic         i_resp, d_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         arb_busy;

    logic         mem_resp = 1'b0, spur_resp = 1'b0, mem_off = 1'b0;
    logic [127:0] mem_rdata = '0, spur_rdata = '0;

    assign pmem_resp  = mem_resp | spur_resp;
    assign pmem_rdata = spur_resp ? spur_rdata : mem_rdata;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_busy(arb_busy)
    );

    typedef struct {
        logic         side;   // 0 = I, 1 = D
        logic [15:0]  addr;
        logic         rd;
        logic         wr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    txn_t exp_cmd[$];
    txn_t exp_resp[$];
    int   total = 0;
    int   bad   = 0;
    bit   last_d = 1'b1;   // model of the round-robin pointer: D granted last

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response monitor: every resp must match the next predicted transaction.
    initial begin
        forever begin
            @(negedge clk);
            check("one_resp_at_a_time", {126'd0, i_resp, d_resp} == 128'd3, 128'd0);
            if (i_resp || d_resp) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp", {126'd0, i_resp, d_resp}, 128'd0);
                end else begin
                    txn_t e;
                    e = exp_resp.pop_front();
                    check("resp_side", {127'd0, d_resp}, {127'd0, e.side});
                    check("resp_rdata", d_resp ? d_rdata : i_rdata, e.rdata);
                    check("other_rdata_zero", d_resp ? i_rdata : d_rdata, 128'd0);
                end
            end else begin
                check("rdata_zero_no_resp", i_rdata | d_rdata, 128'd0);
            end
            if (!arb_busy)
                check("idle_no_strobe", {126'd0, pmem_read, pmem_write}, 128'd0);
        end
    end

    // Memory model: checks each command against the prediction, then answers after a random delay.
    initial begin
        txn_t cur;
        bit   active = 1'b0;
        int   delay  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                mem_resp = 1'b0;
            end else if (!mem_off && (pmem_read || pmem_write)) begin
                if (!active) begin
                    if (exp_cmd.size() == 0) begin
                        check("unexpected_cmd", 128'd1, 128'd0);
                        cur.side = 1'b0; cur.addr = pmem_addr; cur.rd = pmem_read;
                        cur.wr = pmem_write; cur.wdata = pmem_wdata; cur.rdata = '0;
                    end else begin
                        cur = exp_cmd.pop_front();
                    end
                    active = 1'b1;
                    delay  = $urandom_range(0, 3);
                end
                check("cmd_addr", {112'd0, pmem_addr}, {112'd0, cur.addr});
                check("cmd_rd", {127'd0, pmem_read}, {127'd0, cur.rd});
                check("cmd_wr", {127'd0, pmem_write}, {127'd0, cur.wr});
                if (cur.side)
                    check("cmd_wdata", pmem_wdata, cur.wdata);
                if (delay == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = cur.rdata;
                    active    = 1'b0;
                end else begin
                    delay--;
                end
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One arbitration round: predict grant order from the model, drive requests, wait for both resps.
    task automatic do_round(input bit want_i, input bit want_d, input logic [15:0] ia,
                            input logic [15:0] da, input bit dr, input bit dw,
                            input logic [127:0] wd, input bit withdraw, input logic [127:0] rdi);
        txn_t ti, td;
        bit   first_d;
        bit   pend_i, pend_d;
        int   cyc;
        @(negedge clk);
        check("idle_gap", {127'd0, arb_busy}, 128'd0);
        ti.side = 1'b0; ti.addr = ia; ti.rd = 1'b1; ti.wr = 1'b0; ti.wdata = '0; ti.rdata = rdi;
        td.side = 1'b1; td.addr = da; td.rd = dr & ~dw; td.wr = dw; td.wdata = wd; td.rdata = rnd128();
        first_d = (want_i && want_d) ? ~last_d : want_d;
        if (first_d) begin
            exp_cmd.push_back(td); exp_resp.push_back(td);
            if (want_i) begin exp_cmd.push_back(ti); exp_resp.push_back(ti); end
        end else begin
            exp_cmd.push_back(ti); exp_resp.push_back(ti);
            if (want_d) begin exp_cmd.push_back(td); exp_resp.push_back(td); end
        end
        last_d = (want_i && want_d) ? ~first_d : first_d;
        i_read = want_i; i_addr = ia;
        d_read = want_d & dr; d_write = want_d & dw; d_addr = da; d_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        check("grant_latency_busy", {127'd0, arb_busy}, 128'd1);
        check("grant_latency_strobe", {127'd0, pmem_read | pmem_write}, 128'd1);
        if (withdraw && !first_d) begin
            i_read = 1'b0;
            i_addr = 16'hFFF0;
        end
        pend_i = want_i; pend_d = want_d; cyc = 0;
        while ((pend_i || pend_d) && cyc < 100) begin
            if (withdraw && arb_busy && !first_d && pend_i)
                check("withdraw_addr_held", {112'd0, pmem_addr}, {112'd0, ia});
            if (i_resp) begin i_read = 1'b0; pend_i = 1'b0; end
            if (d_resp) begin d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0; end
            if (pend_i || pend_d) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (cyc >= 100)
            check("round_timeout", 128'd1, 128'd0);
    endtask

    // Pulse pmem_resp while idle with nobody requesting.
    task automatic spurious();
        @(negedge clk);
        spur_resp  = 1'b1;
        spur_rdata = rnd128();
        #1;
        check("spur_no_i_resp", {127'd0, i_resp}, 128'd0);
        check("spur_no_d_resp", {127'd0, d_resp}, 128'd0);
        @(negedge clk);
        check("spur_stays_idle", {127'd0, arb_busy}, 128'd0);
        spur_resp = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #12;
        check("reset_busy", {127'd0, arb_busy}, 128'd0);
        check("reset_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
        check("reset_addr", {112'd0, pmem_addr}, 128'd0);
        check("reset_wdata", pmem_wdata, 128'd0);
        check("reset_resps", {126'd0, i_resp, d_resp}, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases first, then random traffic.
        do_round(1, 0, 16'h0040, 16'h0, 0, 0, '0, 0, {16{8'hA5}});
        do_round(1, 1, 16'h0100, 16'h0200, 1, 0, rnd128(), 0, rnd128());
        do_round(1, 1, 16'h0110, 16'h0210, 1, 0, rnd128(), 0, rnd128());
        do_round(0, 1, 16'h0, 16'h1230, 1, 1, {4{32'hDEADBEEF}}, 0, '0);
        do_round(1, 0, 16'h0480, 16'h0, 0, 0, '0, 1, rnd128());
        spurious();
        for (int r = 0; r < 60; r++) begin
            int  mode;
            int  op;
            mode = $urandom_range(0, 2);
            op   = $urandom_range(0, 2);
            do_round(mode != 1, mode != 0, 16'($urandom) & 16'hFFF0, 16'($urandom) & 16'hFFF0,
                     op != 1, op != 0, rnd128(), $urandom_range(0, 3) == 0, rnd128());
            if ($urandom_range(0, 7) == 0)
                spurious();
        end

        // Reset in the middle of a D writeback.
        @(negedge clk);
        mem_off = 1'b1;
        d_write = 1'b1; d_addr = 16'h2220; d_wdata = rnd128();
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_write", {127'd0, pmem_write}, 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
        check("abort_busy", {127'd0, arb_busy}, 128'd0);
        check("abort_no_d_resp", {127'd0, d_resp}, 128'd0);
        d_write = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mem_off = 1'b0;
        last_d  = 1'b1;
        do_round(1, 1, 16'h0330, 16'h0440, 1, 0, rnd128(), 0, rnd128());

        repeat (4) @(negedge clk);
        check("resp_queue_drained", 128'(exp_resp.size()), 128'd0);
        check("cmd_queue_drained", 128'(exp_cmd.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-fetch cache (mem1 side) and the data cache (mem2 side) of the pipelined LC-3b core.
- Latches one requester's command at grant, drives it to memory, and routes the response back to that requester only.
- Round-robin grant on ties, so neither pipeline stage starves the other.

Parameters:
- ADDR_W, 16, byte address width of both ports and of memory.
- LINE_W, 128, cache-line data width in bits.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line-read request; held until i_resp.
- i_addr  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line-read request.
- d_write  in  1  dcache line-write (writeback) request.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  memory read strobe; held until pmem_resp.
- pmem_write  out  1  memory write strobe; held until pmem_resp.
- pmem_addr  out  ADDR_W  latched address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.
- arb_busy  out  1  high whenever state is not IDLE.

Behaviour:
- State machine:
  - States are IDLE, SERVE_I and SERVE_D.
  - A state register last_grant (I/D) resets to D.
  - Command registers cmd_addr, cmd_wdata, cmd_rd and cmd_wr reset to 0.
- Reset: asserting reset_n low forces the following immediately, including mid-transaction:
  - state to IDLE and last_grant to D;
  - all command registers to 0;
  - every output to 0.
  - No response is issued for an aborted transaction.
- Arbitration in IDLE, at the rising edge:
  - Only the I request pending (i_read): go to SERVE_I.
  - Only the D request pending (d_read|d_write): go to SERVE_D.
  - Both pending: grant the side opposite last_grant.
  - On a grant, latch the granted address, plus d_wdata for D, into the command registers, and set last_grant to the granted side.
  - Neither pending: stay in IDLE.
- Command latching:
  - For I: cmd_rd=1, cmd_wr=0.
  - For D: cmd_wr=d_write, cmd_rd=d_read&~d_write. If both d_read and d_write are high, the write wins and the read is dropped.
- Memory drive:
  - In SERVE_x: pmem_read=cmd_rd, pmem_write=cmd_wr, pmem_addr=cmd_addr, pmem_wdata=cmd_wdata. These are all from registers, so they are stable for the whole transaction.
  - In IDLE: all pmem outputs are 0.
- Minimum latency: the request is seen at edge N, and pmem strobes are high during cycle N+1.
- Completion:
  - In SERVE_x with pmem_resp=1, x_resp=1 combinationally in the same cycle, and x_rdata=pmem_rdata.
  - The other side's resp stays 0.
  - Next state is IDLE. There is always at least one IDLE cycle between transactions.
- rdata outside the resp cycle: i_rdata and d_rdata are 0 when their resp is low.
- Request withdrawn mid-transaction: ignored. The latched command completes and a resp is still pulsed.
- Request changes while in SERVE: not sampled until the next IDLE.
- pmem_resp in IDLE: ignored, and no resp is pulsed.
- Requester obligation: a requester drops its request the cycle after its resp. If it is still high in the following IDLE, it is treated as a new request.

Test Plan:
- Single I read: i_read=1, i_addr=16'h0040; memory responds 3 cycles after strobe with rdata=128'hA5…A5.
  - Required: pmem_read high with pmem_addr=16'h0040 from cycle N+1 until resp.
  - Required: i_resp pulses once with i_rdata=128'hA5…A5; d_resp stays 0.
- Simultaneous requests out of reset: i_read and d_read asserted together.
  - Required: I is served first (last_grant=D after reset).
  - Required: after i_resp and one IDLE cycle, D is served; a repeated tie then grants I.
- D write-with-read: d_read=1, d_write=1, d_addr=16'h1230, d_wdata=X.
  - Required: pmem_write=1, pmem_read=0, pmem_wdata=X; d_resp on pmem_resp.
- Withdrawal: i_read dropped one cycle after grant, with i_addr changing to 16'hFFF0.
  - Required: pmem_addr holds the original value and i_resp still pulses.
- Reset mid-transaction: reset_n low while in SERVE_D.
  - Required: pmem_write/pmem_read drop immediately and no d_resp is issued.
  - Required: after release, a tie grants I.
- Spurious pmem_resp in IDLE: no i_resp/d_resp, state stays IDLE, arb_busy=0.
